cycle_sequencer: RTL

Instruction-cycle controller for the 8-bit core. Generates the four one-hot phase strobes `q1`..`q4` that drive `clk1`..`clk4` of the decoder and datapath. Owns the program counter, instruction register and hardware return stack, and runs a two-stage fetch/execute pipeline. Fetch of instruction n+1 overlaps execution of instruction n. Branch, call, return and skip requests from the datapath flush the prefetched word.

---
 rtl/cycle_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: four-phase instruction-cycle controller for the 8-bit core.
// Owns the PC, instruction register and circular return stack. Fetch of the
// next word overlaps execution of the current one; control-flow requests
// taken in Q4 flush the prefetched word.
module cycle_sequencer #(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic [7:0]      prog_data,
  input  logic            skip_req,
  input  logic            branch_req,
  input  logic            call_req,
  input  logic            ret_req,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] prog_addr,
  output logic [7:0]      inst_reg,
  output logic            exec_valid,
  output logic            q1,
  output logic            q2,
  output logic            q3,
  output logic            q4,
  output logic            halted,
  output logic            stack_err
);

  localparam int SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W:0] FULL_COUNT = (SP_W+1)'(STACK_DEPTH);

  typedef enum logic [2:0] {HALT, Q1, Q2, Q3, Q4} state_t;

  state_t          state;
  state_t          state_next;

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic            flush;
  logic            do_push;
  logic            do_pop;

  // Return stack: sp points at the next free slot; count tracks occupancy
  // so that full/empty can be told apart on the circular buffer.
  logic [PC_W-1:0] stack [STACK_DEPTH];
  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] sp_dec;
  logic [SP_W:0]   count;

  assign prog_addr = pc;
  assign sp_dec    = sp - SP_W'(1);

  // Phase sequencing: HALT until run, then Q1..Q4, run re-checked at Q4 only.
  always_comb begin
    state_next = HALT;
    unique case (state)
      HALT:    state_next = run ? Q1 : HALT;
      Q1:      state_next = Q2;
      Q2:      state_next = Q3;
      Q3:      state_next = Q4;
      Q4:      state_next = run ? Q1 : HALT;
      default: state_next = HALT;
    endcase
  end

  // Next-PC selection for the instruction boundary; call > ret > branch > skip,
  // and nothing is honoured while the executing word is a flushed/dummy NOP.
  always_comb begin
    pc_next = pc + PC_W'(1);
    flush   = 1'b0;
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (exec_valid) begin
      if (call_req) begin
        do_push = 1'b1;
        pc_next = branch_target;
        flush   = 1'b1;
      end else if (ret_req) begin
        do_pop  = 1'b1;
        pc_next = stack[sp_dec];
        flush   = 1'b1;
      end else if (branch_req) begin
        pc_next = branch_target;
        flush   = 1'b1;
      end else if (skip_req) begin
        flush   = 1'b1;
      end
    end
  end

  // FSM state plus registered phase strobes and idle flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= HALT;
      q1     <= 1'b0;
      q2     <= 1'b0;
      q3     <= 1'b0;
      q4     <= 1'b0;
      halted <= 1'b1;
    end else begin
      state  <= state_next;
      q1     <= (state_next == Q1);
      q2     <= (state_next == Q2);
      q3     <= (state_next == Q3);
      q4     <= (state_next == Q4);
      halted <= (state_next == HALT);
    end
  end

  // Instruction boundary: latch fetched word, advance PC, mark validity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      inst_reg   <= '0;
      exec_valid <= 1'b0;
    end else if (state == Q4) begin
      pc         <= pc_next;
      inst_reg   <= prog_data;
      exec_valid <= ~flush;
    end
  end

  // Return stack push/pop with sticky overflow/underflow reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack[i] <= '0;
      end
      sp        <= '0;
      count     <= '0;
      stack_err <= 1'b0;
    end else if (state == Q4) begin
      if (do_push) begin
        // When full, the slot at sp holds the oldest entry and is overwritten.
        stack[sp] <= pc;
        sp        <= sp + SP_W'(1);
        if (count == FULL_COUNT) begin
          stack_err <= 1'b1;
        end else begin
          count <= count + (SP_W+1)'(1);
        end
      end else if (do_pop) begin
        sp <= sp_dec;
        if (count == '0) begin
          stack_err <= 1'b1;
        end else begin
          count <= count - (SP_W+1)'(1);
        end
      end
    end
  end

endmodule
